// File: rtl/pe_pkg.sv
// Shared helpers for the systolic PE: width-generic saturating add, product
// extension and the rail values the accumulator clamps to.
package pe_pkg;

  localparam int MAX_W = 64;
  localparam logic [MAX_W-1:0] ONE        = {{(MAX_W-1){1'b0}}, 1'b1};
  localparam logic [MAX_W-1:0] U_RAIL     = {MAX_W{1'b1}};
  localparam logic [MAX_W-1:0] S_RAIL_POS = {1'b0, {(MAX_W-1){1'b1}}};
  localparam logic [MAX_W-1:0] S_RAIL_NEG = {1'b1, {(MAX_W-1){1'b0}}};

  typedef struct packed {
    logic             ovf;
    logic [MAX_W-1:0] sum;
  } sat_res_t;

  function automatic logic [MAX_W-1:0] width_mask(input int w);
    return U_RAIL >> (MAX_W - w);
  endfunction

  // Widen a pw-bit product, held right-justified, to w bits.
  function automatic logic [MAX_W-1:0] ext_prod(input logic [MAX_W-1:0] p,
                                                input int pw, input int w,
                                                input logic is_signed);
    logic [MAX_W-1:0] hi;
    logic             sgn;
    sgn = |(p & (ONE << (pw - 1)));
    hi  = (U_RAIL << pw) & width_mask(w);
    return (p & ~(U_RAIL << pw)) | ((is_signed && sgn) ? hi : '0);
  endfunction

  // w-bit add on right-justified operands; signed rails are the MAX_W rails
  // shifted down so their top bit lands on bit w-1.
  function automatic sat_res_t sat_add(input logic [MAX_W-1:0] a,
                                       input logic [MAX_W-1:0] b,
                                       input int w, input logic is_signed,
                                       input logic sat);
    logic [MAX_W-1:0] mask, am, bm, msb;
    logic [MAX_W:0]   s;
    logic             sa, sb, ss, cy, ov;
    sat_res_t         r;
    mask = width_mask(w);
    msb  = ONE << (w - 1);
    am   = a & mask;
    bm   = b & mask;
    s    = {1'b0, am} + {1'b0, bm};
    cy   = |(s & ({1'b0, ONE} << w));
    sa   = |(am & msb);
    sb   = |(bm & msb);
    ss   = |(s[MAX_W-1:0] & msb);
    ov   = is_signed ? ((sa == sb) && (ss != sa)) : cy;
    r.ovf = ov;
    if (ov && sat) begin
      if (!is_signed)  r.sum = mask;
      else if (sa)     r.sum = S_RAIL_NEG >> (MAX_W - w);
      else             r.sum = S_RAIL_POS >> (MAX_W - w);
    end else begin
      r.sum = s[MAX_W-1:0] & mask;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_mac_acc.sv
// Multiply-accumulate core of the PE: product, extension, saturating add,
// and the accumulator / sticky overflow registers.
module pe_mac_acc
  import pe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter bit SIGNED = 1'b0,
  parameter bit SAT    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              fire,
  input  logic              acc_clr,
  input  logic              drain_ld,
  output logic [ACC_W-1:0]  nxt,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

  logic [2*DATA_W-1:0] a_ext, b_ext, prod;
  logic [MAX_W-1:0]    addend;
  sat_res_t            add_r;
  logic                add_ovf;
  logic                unused_sum;

  // Extending both operands to 2*DATA_W lets one unsigned multiply serve both
  // signednesses: the low 2*DATA_W bits of the product are the same.
  always_comb begin
    if (SIGNED) begin
      a_ext = {{DATA_W{a[DATA_W-1]}}, a};
      b_ext = {{DATA_W{b[DATA_W-1]}}, b};
    end else begin
      a_ext = {{DATA_W{1'b0}}, a};
      b_ext = {{DATA_W{1'b0}}, b};
    end
    prod   = a_ext * b_ext;
    addend = fire ? ext_prod(MAX_W'(prod), 2 * DATA_W, ACC_W, SIGNED) : '0;
    add_r  = sat_add(acc_clr ? '0 : MAX_W'(acc), addend, ACC_W, SIGNED, SAT);
  end

  assign nxt        = add_r.sum[ACC_W-1:0];
  assign add_ovf    = add_r.ovf;
  assign unused_sum = ^add_r.sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      acc <= drain_ld ? '0 : nxt;
      ovf <= (ovf & ~(acc_clr | drain_ld)) | add_ovf;
    end
  end

endmodule

// File: rtl/systolic_pe.sv
// Output-stationary systolic PE: forwards operands east/south, accumulates
// when both are valid, and drains results down a per-column shift chain.
module systolic_pe
  import pe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter bit SIGNED = 1'b0,
  parameter bit SAT    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_vld_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_vld_in,
  input  logic              acc_clr,
  input  logic              drain_ld,
  input  logic [ACC_W-1:0]  res_in,
  input  logic              res_vld_in,
  output logic [DATA_W-1:0] a_out,
  output logic              a_vld_out,
  output logic [DATA_W-1:0] b_out,
  output logic              b_vld_out,
  output logic [ACC_W-1:0]  res_out,
  output logic              res_vld_out,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

  logic [ACC_W-1:0] nxt;

  pe_mac_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED),
    .SAT    (SAT)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .a        (a_in),
    .b        (b_in),
    .fire     (a_vld_in & b_vld_in),
    .acc_clr  (acc_clr),
    .drain_ld (drain_ld),
    .nxt      (nxt),
    .acc      (acc),
    .ovf      (ovf)
  );

  // A local drain overrides whatever the PE above is shifting down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out       <= '0;
      a_vld_out   <= 1'b0;
      b_out       <= '0;
      b_vld_out   <= 1'b0;
      res_out     <= '0;
      res_vld_out <= 1'b0;
    end else begin
      a_out       <= a_in;
      a_vld_out   <= a_vld_in;
      b_out       <= b_in;
      b_vld_out   <= b_vld_in;
      res_out     <= drain_ld ? nxt : res_in;
      res_vld_out <= drain_ld | res_vld_in;
    end
  end

endmodule

// File: tb/tb_systolic_pe.sv
// Directed bench for systolic_pe: a 4-PE default column plus one signed
// saturating PE and one unsigned wrapping PE sharing a stimulus bundle.
module tb_systolic_pe;

  localparam int DW = 8;
  localparam int AW = 20;
  localparam int N  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] c_a [N];
  logic [DW-1:0] c_b [N];
  logic          c_av[N];
  logic          c_bv[N];
  logic          c_clr, c_drain;
  logic [DW-1:0] a_o [N];
  logic [DW-1:0] b_o [N];
  logic          avo [N];
  logic          bvo [N];
  logic [AW-1:0] res_o[N];
  logic [AW-1:0] res_i[N];
  logic          rvo [N];
  logic          rvi [N];
  logic [AW-1:0] acc_o[N];
  logic          ovf_o[N];

  for (genvar k = 0; k < N; k++) begin : g_col
    if (k == 0) begin : g_head
      assign res_i[k] = '0;
      assign rvi[k]   = 1'b0;
    end else begin : g_link
      assign res_i[k] = res_o[k-1];
      assign rvi[k]   = rvo[k-1];
    end
    systolic_pe #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1'b0), .SAT(1'b1)) u_pe (
      .clk(clk), .rst(rst),
      .a_in(c_a[k]), .a_vld_in(c_av[k]), .b_in(c_b[k]), .b_vld_in(c_bv[k]),
      .acc_clr(c_clr), .drain_ld(c_drain),
      .res_in(res_i[k]), .res_vld_in(rvi[k]),
      .a_out(a_o[k]), .a_vld_out(avo[k]), .b_out(b_o[k]), .b_vld_out(bvo[k]),
      .res_out(res_o[k]), .res_vld_out(rvo[k]),
      .acc(acc_o[k]), .ovf(ovf_o[k])
    );
  end

  logic [DW-1:0] s_a, s_b;
  logic          s_av, s_bv, s_clr, s_drain;
  logic [DW-1:0] sg_a, sg_b, wr_a, wr_b;
  logic          sg_av, sg_bv, sg_rv, sg_ovf, wr_av, wr_bv, wr_rv, wr_ovf;
  logic [AW-1:0] sg_res, sg_acc, wr_res, wr_acc;

  systolic_pe #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1'b1), .SAT(1'b1)) u_sgn (
    .clk(clk), .rst(rst),
    .a_in(s_a), .a_vld_in(s_av), .b_in(s_b), .b_vld_in(s_bv),
    .acc_clr(s_clr), .drain_ld(s_drain), .res_in('0), .res_vld_in(1'b0),
    .a_out(sg_a), .a_vld_out(sg_av), .b_out(sg_b), .b_vld_out(sg_bv),
    .res_out(sg_res), .res_vld_out(sg_rv), .acc(sg_acc), .ovf(sg_ovf)
  );

  systolic_pe #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1'b0), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst),
    .a_in(s_a), .a_vld_in(s_av), .b_in(s_b), .b_vld_in(s_bv),
    .acc_clr(s_clr), .drain_ld(s_drain), .res_in('0), .res_vld_in(1'b0),
    .a_out(wr_a), .a_vld_out(wr_av), .b_out(wr_b), .b_vld_out(wr_bv),
    .res_out(wr_res), .res_vld_out(wr_rv), .acc(wr_acc), .ovf(wr_ovf)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    for (int k = 0; k < N; k++) begin
      c_av[k] = 1'b0;
      c_bv[k] = 1'b0;
    end
    c_clr = 1'b0; c_drain = 1'b0;
    s_av = 1'b0; s_bv = 1'b0; s_clr = 1'b0; s_drain = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({a_o[k], avo[k], b_o[k], bvo[k], res_o[k], rvo[k], acc_o[k], ovf_o[k]} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_col%0d: got %h, expected 0", k,
                 {a_o[k], avo[k], b_o[k], bvo[k], res_o[k], rvo[k], acc_o[k], ovf_o[k]});
      end
    end
    checks++;
    if ({sg_a, sg_av, sg_b, sg_bv, sg_res, sg_rv, sg_acc, sg_ovf,
         wr_a, wr_av, wr_b, wr_bv, wr_res, wr_rv, wr_acc, wr_ovf} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_sgn_wrap: got %h/%h, expected 0",
               {sg_a, sg_av, sg_b, sg_bv, sg_res, sg_rv, sg_acc, sg_ovf},
               {wr_a, wr_av, wr_b, wr_bv, wr_res, wr_rv, wr_acc, wr_ovf});
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unsigned_mac;
    idle();
    for (int i = 0; i < 4; i++) begin
      c_a[0] = 8'd3; c_b[0] = 8'd5; c_av[0] = 1'b1; c_bv[0] = 1'b1;
      tick();
      checks++;
      if (acc_o[0] !== 20'(15 * (i + 1))) begin
        errors++;
        $display("[TB] FAIL mac_acc_%0d: got %0d, expected %0d", i, acc_o[0], 15 * (i + 1));
      end
      checks++;
      if ({a_o[0], avo[0], b_o[0], bvo[0]} !== {8'd3, 1'b1, 8'd5, 1'b1}) begin
        errors++;
        $display("[TB] FAIL fwd_%0d: got %h, expected %h", i,
                 {a_o[0], avo[0], b_o[0], bvo[0]}, {8'd3, 1'b1, 8'd5, 1'b1});
      end
    end
    c_a[0] = 8'd9; c_b[0] = 8'd77; c_av[0] = 1'b1; c_bv[0] = 1'b0;
    tick();
    checks++;
    if (acc_o[0] !== 20'd60) begin
      errors++;
      $display("[TB] FAIL mac_a_only: got %0d, expected 60", acc_o[0]);
    end
    checks++;
    if ({a_o[0], avo[0], b_o[0], bvo[0]} !== {8'd9, 1'b1, 8'd77, 1'b0}) begin
      errors++;
      $display("[TB] FAIL fwd_invalid: got %h, expected %h",
               {a_o[0], avo[0], b_o[0], bvo[0]}, {8'd9, 1'b1, 8'd77, 1'b0});
    end
    c_av[0] = 1'b0; c_bv[0] = 1'b1;
    tick();
    checks++;
    if (acc_o[0] !== 20'd60) begin
      errors++;
      $display("[TB] FAIL mac_b_only: got %0d, expected 60", acc_o[0]);
    end
    idle();
  endtask

  task automatic test_unsigned_sat;
    idle();
    c_clr = 1'b1;
    tick();
    c_clr = 1'b0;
    c_a[0] = 8'd255; c_b[0] = 8'd255; c_av[0] = 1'b1; c_bv[0] = 1'b1;
    repeat (16) tick();
    checks++;
    if ({ovf_o[0], acc_o[0]} !== {1'b0, 20'd1040400}) begin
      errors++;
      $display("[TB] FAIL usat_16: got ovf=%b acc=%0d, expected ovf=0 acc=1040400", ovf_o[0], acc_o[0]);
    end
    tick();
    checks++;
    if ({ovf_o[0], acc_o[0]} !== {1'b1, 20'd1048575}) begin
      errors++;
      $display("[TB] FAIL usat_17: got ovf=%b acc=%0d, expected ovf=1 acc=1048575", ovf_o[0], acc_o[0]);
    end
    tick();
    checks++;
    if (acc_o[0] !== 20'd1048575) begin
      errors++;
      $display("[TB] FAIL usat_hold: got %0d, expected 1048575", acc_o[0]);
    end
    idle();
    c_clr = 1'b1;
    tick();
    checks++;
    if ({ovf_o[0], acc_o[0]} !== {1'b0, 20'd0}) begin
      errors++;
      $display("[TB] FAIL usat_clr: got ovf=%b acc=%0d, expected ovf=0 acc=0", ovf_o[0], acc_o[0]);
    end
    idle();
  endtask

  task automatic test_signed_sat;
    idle();
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    s_a = 8'h80; s_b = 8'h80; s_av = 1'b1; s_bv = 1'b1;
    repeat (31) tick();
    checks++;
    if ({sg_ovf, sg_acc} !== {1'b0, 20'd507904}) begin
      errors++;
      $display("[TB] FAIL ssat_31: got ovf=%b acc=%0d, expected ovf=0 acc=507904", sg_ovf, sg_acc);
    end
    tick();
    checks++;
    if ({sg_ovf, sg_acc} !== {1'b1, 20'd524287}) begin
      errors++;
      $display("[TB] FAIL ssat_32: got ovf=%b acc=%0d, expected ovf=1 acc=524287", sg_ovf, sg_acc);
    end
    s_a = 8'hFF; s_b = 8'h01;
    tick();
    checks++;
    if ({sg_ovf, sg_acc} !== {1'b1, 20'd524286}) begin
      errors++;
      $display("[TB] FAIL ssat_off_rail: got ovf=%b acc=%0d, expected ovf=1 acc=524286", sg_ovf, sg_acc);
    end
    s_clr = 1'b1; s_a = 8'h80; s_b = 8'h7F;
    tick();
    s_clr = 1'b0;
    repeat (31) tick();
    checks++;
    if ({sg_ovf, sg_acc} !== {1'b0, 20'd528384}) begin
      errors++;
      $display("[TB] FAIL ssat_neg_32: got ovf=%b acc=%h, expected ovf=0 acc=81000", sg_ovf, sg_acc);
    end
    tick();
    checks++;
    if ({sg_ovf, sg_acc} !== {1'b1, 20'h80000}) begin
      errors++;
      $display("[TB] FAIL ssat_neg_rail: got ovf=%b acc=%h, expected ovf=1 acc=80000", sg_ovf, sg_acc);
    end
    idle();
  endtask

  task automatic test_wrap;
    idle();
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    s_a = 8'd255; s_b = 8'd255; s_av = 1'b1; s_bv = 1'b1;
    repeat (17) tick();
    checks++;
    if ({wr_ovf, wr_acc} !== {1'b1, 20'd56849}) begin
      errors++;
      $display("[TB] FAIL wrap_17: got ovf=%b acc=%0d, expected ovf=1 acc=56849", wr_ovf, wr_acc);
    end
    s_av = 1'b0; s_bv = 1'b0; s_drain = 1'b1;
    tick();
    s_drain = 1'b0;
    checks++;
    if ({wr_rv, wr_res, wr_ovf, wr_acc} !== {1'b1, 20'd56849, 1'b0, 20'd0}) begin
      errors++;
      $display("[TB] FAIL wrap_drain: got vld=%b res=%0d ovf=%b acc=%0d, expected vld=1 res=56849 ovf=0 acc=0",
               wr_rv, wr_res, wr_ovf, wr_acc);
    end
    idle();
  endtask

  task automatic test_drain_chain;
    idle();
    c_clr = 1'b1;
    for (int k = 0; k < N; k++) begin
      c_a[k] = 8'(10 * (k + 1)); c_b[k] = 8'd1; c_av[k] = 1'b1; c_bv[k] = 1'b1;
    end
    tick();
    idle();
    for (int k = 0; k < N; k++) begin
      checks++;
      if (acc_o[k] !== 20'(10 * (k + 1))) begin
        errors++;
        $display("[TB] FAIL chain_load_%0d: got %0d, expected %0d", k, acc_o[k], 10 * (k + 1));
      end
    end
    c_drain = 1'b1;
    tick();
    c_drain = 1'b0;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (acc_o[k] !== 20'd0) begin
        errors++;
        $display("[TB] FAIL chain_acc0_%0d: got %0d, expected 0", k, acc_o[k]);
      end
    end
    for (int j = 0; j < N; j++) begin
      checks++;
      if ({rvo[N-1], res_o[N-1]} !== {1'b1, 20'(40 - 10 * j)}) begin
        errors++;
        $display("[TB] FAIL chain_out_%0d: got vld=%b res=%0d, expected vld=1 res=%0d",
                 j + 1, rvo[N-1], res_o[N-1], 40 - 10 * j);
      end
      tick();
    end
    checks++;
    if (rvo[N-1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL chain_end: got vld=%b, expected 0", rvo[N-1]);
    end
  endtask

  task automatic test_simultaneous;
    idle();
    c_clr = 1'b1; c_a[0] = 8'd10; c_b[0] = 8'd10; c_av[0] = 1'b1; c_bv[0] = 1'b1;
    tick();
    checks++;
    if (acc_o[0] !== 20'd100) begin
      errors++;
      $display("[TB] FAIL sim_load100: got %0d, expected 100", acc_o[0]);
    end
    c_a[0] = 8'd2; c_b[0] = 8'd7;
    tick();
    checks++;
    if (acc_o[0] !== 20'd14) begin
      errors++;
      $display("[TB] FAIL sim_clr_fire: got %0d, expected 14", acc_o[0]);
    end
    c_a[0] = 8'd5; c_b[0] = 8'd1;
    tick();
    c_clr = 1'b0; c_drain = 1'b1; c_a[0] = 8'd1; c_b[0] = 8'd1;
    tick();
    checks++;
    if ({rvo[0], res_o[0], acc_o[0]} !== {1'b1, 20'd6, 20'd0}) begin
      errors++;
      $display("[TB] FAIL sim_drain_fire: got vld=%b res=%0d acc=%0d, expected vld=1 res=6 acc=0",
               rvo[0], res_o[0], acc_o[0]);
    end
    c_drain = 1'b0; c_a[0] = 8'd3; c_b[0] = 8'd3;
    tick();
    c_clr = 1'b1; c_drain = 1'b1; c_a[0] = 8'd2; c_b[0] = 8'd2;
    tick();
    checks++;
    if ({rvo[0], res_o[0], acc_o[0]} !== {1'b1, 20'd4, 20'd0}) begin
      errors++;
      $display("[TB] FAIL sim_clr_drain: got vld=%b res=%0d acc=%0d, expected vld=1 res=4 acc=0",
               rvo[0], res_o[0], acc_o[0]);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_drain;
    idle();
    c_clr = 1'b1;
    for (int k = 0; k < N; k++) begin
      c_a[k] = 8'(k + 1); c_b[k] = 8'd1; c_av[k] = 1'b1; c_bv[k] = 1'b1;
    end
    tick();
    idle();
    for (int k = 0; k < N; k++) begin
      c_a[k] = 8'h5A; c_av[k] = 1'b1;
    end
    c_drain = 1'b1;
    tick();
    c_drain = 1'b0;
    tick();
    checks++;
    if ({rvo[N-1], res_o[N-1], a_o[N-1]} !== {1'b1, 20'd3, 8'h5A}) begin
      errors++;
      $display("[TB] FAIL rst_pre: got vld=%b res=%0d a=%h, expected vld=1 res=3 a=5a",
               rvo[N-1], res_o[N-1], a_o[N-1]);
    end
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({a_o[k], avo[k], b_o[k], bvo[k], res_o[k], rvo[k], acc_o[k], ovf_o[k]} !== '0) begin
        errors++;
        $display("[TB] FAIL rst_async_%0d: got %h, expected 0", k,
                 {a_o[k], avo[k], b_o[k], bvo[k], res_o[k], rvo[k], acc_o[k], ovf_o[k]});
      end
    end
    idle();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({rvo[N-1], res_o[N-1]} !== {1'b0, 20'd0}) begin
      errors++;
      $display("[TB] FAIL rst_chain_flushed: got vld=%b res=%0d, expected vld=0 res=0",
               rvo[N-1], res_o[N-1]);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      c_a[k] = '0;
      c_b[k] = '0;
    end
    s_a = '0; s_b = '0;
    idle();
    test_reset();
    test_unsigned_mac();
    test_unsigned_sat();
    test_signed_sat();
    test_wrap();
    test_drain_chain();
    test_simultaneous();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no completion, expected finish before 100000");
    $fatal(1, "[TB] timeout");
  end

endmodule
